// File: rtl/online_pkg.sv
// Shared definitions for the radix-2 online multiplier: sequencer states,
// signed-digit encodings and the iteration counter width helper.
package online_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Two's complement signed digits in {-1, 0, +1}
   localparam logic [1:0] DIG_ZERO = 2'b00;
   localparam logic [1:0] DIG_POS  = 2'b01;
   localparam logic [1:0] DIG_NEG  = 2'b11;

   // Bits needed to hold values 0..max_count-1 (never less than one bit)
   function automatic int cnt_width(input int max_count);
      cnt_width = (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/online_mult_seq.sv
// Sequencer for a radix-2 MSD-first online multiplier. It accepts a start
// command, streams NO_OF_DIGITS operand digit pairs in, runs
// NO_OF_DIGITS+DELTA recurrence iterations (selection forced to zero during
// the DELTA-iteration online delay) and streams NO_OF_DIGITS result digits out.
// DELTA must be at least 1 and NO_OF_DIGITS must be at least DELTA.
module online_mult_seq
   import online_pkg::*;
#(
   parameter int NO_OF_DIGITS = 8,
   parameter int RADIX_BITS   = 2,
   parameter int DELTA        = 3,
   parameter int CNT_W        = cnt_width(NO_OF_DIGITS + DELTA + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  pad_zero,
   output logic                  iter_en,
   output logic                  residual_clr,
   output logic                  sel_force_zero,
   input  logic [RADIX_BITS-1:0] sel_digit,
   output logic [CNT_W-1:0]      iter_idx,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [RADIX_BITS-1:0] out_digit,
   output logic                  out_last,
   output logic                  done
);

   localparam logic [CNT_W-1:0] N_C       = CNT_W'(NO_OF_DIGITS);
   localparam logic [CNT_W-1:0] DELTA_C   = CNT_W'(DELTA);
   localparam logic [CNT_W-1:0] DELTA_M1  = CNT_W'(DELTA - 1);
   localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(NO_OF_DIGITS + DELTA - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;
   logic             residual_clr_q;

   logic             busy_s;
   logic             run_s;
   logic             need_in_s;
   logic             produce_s;
   logic             in_ok_s;
   logic             adv_ok_s;
   logic             iter_en_s;
   logic             out_valid_s;

   // Handshake and datapath control derived from state and iteration count
   always_comb begin
      busy_s      = (state_q != IDLE);
      run_s       = (state_q == RUN);
      need_in_s   = (cnt_q < N_C);
      produce_s   = (cnt_q >= DELTA_C);
      in_ok_s     = !need_in_s || in_valid;
      // A producing iteration may only advance when its digit is taken,
      // so no operand is consumed without a result digit leaving.
      adv_ok_s    = !produce_s || out_ready;
      iter_en_s   = busy_s && in_ok_s && adv_ok_s;
      out_valid_s = run_s && in_ok_s;
   end

   // Sequencer FSM: IDLE -> INIT (online delay) -> RUN (digit output) -> IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         done_q         <= 1'b0;
         residual_clr_q <= 1'b0;
      end else begin
         done_q         <= 1'b0;
         residual_clr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q        <= INIT;
                  cnt_q          <= '0;
                  residual_clr_q <= 1'b1;
               end
            end
            INIT: begin
               if (iter_en_s) begin
                  cnt_q <= cnt_q + CNT_ONE;
                  if (cnt_q == DELTA_M1) begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (iter_en_s) begin
                  if (cnt_q == LAST_C) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign busy           = busy_s;
   assign in_ready       = busy_s && need_in_s && adv_ok_s;
   assign pad_zero       = busy_s && !need_in_s;
   assign iter_en        = iter_en_s;
   assign residual_clr   = residual_clr_q;
   assign sel_force_zero = !run_s;
   assign iter_idx       = cnt_q;
   assign out_valid      = out_valid_s;
   assign out_digit      = out_valid_s ? sel_digit : RADIX_BITS'(DIG_ZERO);
   assign out_last       = out_valid_s && (cnt_q == LAST_C);
   assign done           = done_q;

endmodule

// File: tb/tb_online_mult_seq.sv
// Directed testbench for online_mult_seq: a default instance (N=8, DELTA=3)
// and an N == DELTA instance (N=3, DELTA=3), checked against hand-derived
// cycle-by-cycle expectations.
module tb_online_mult_seq;

   logic clk = 1'b0;
   logic reset;

   // N=8, DELTA=3 instance
   logic       start0, in_valid0, out_ready0;
   logic [1:0] sel_digit0;
   logic       busy0, in_ready0, pad_zero0, iter_en0, residual_clr0;
   logic       sel_force_zero0, out_valid0, out_last0, done0;
   logic [3:0] iter_idx0;
   logic [1:0] out_digit0;
   logic [8:0] obs0;

   // N=3, DELTA=3 instance
   logic       start1, in_valid1, out_ready1;
   logic [1:0] sel_digit1;
   logic       busy1, in_ready1, pad_zero1, iter_en1, residual_clr1;
   logic       sel_force_zero1, out_valid1, out_last1, done1;
   logic [2:0] iter_idx1;
   logic [1:0] out_digit1;
   logic [8:0] obs1;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   online_mult_seq #(.NO_OF_DIGITS(8), .RADIX_BITS(2), .DELTA(3)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .busy(busy0),
      .in_valid(in_valid0), .in_ready(in_ready0), .pad_zero(pad_zero0),
      .iter_en(iter_en0), .residual_clr(residual_clr0),
      .sel_force_zero(sel_force_zero0), .sel_digit(sel_digit0),
      .iter_idx(iter_idx0), .out_valid(out_valid0), .out_ready(out_ready0),
      .out_digit(out_digit0), .out_last(out_last0), .done(done0)
   );

   online_mult_seq #(.NO_OF_DIGITS(3), .RADIX_BITS(2), .DELTA(3)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .busy(busy1),
      .in_valid(in_valid1), .in_ready(in_ready1), .pad_zero(pad_zero1),
      .iter_en(iter_en1), .residual_clr(residual_clr1),
      .sel_force_zero(sel_force_zero1), .sel_digit(sel_digit1),
      .iter_idx(iter_idx1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_digit(out_digit1), .out_last(out_last1), .done(done1)
   );

   // Flag vector order: busy in_ready pad_zero iter_en residual_clr sel_force_zero out_valid out_last done
   assign obs0 = {busy0, in_ready0, pad_zero0, iter_en0, residual_clr0,
                  sel_force_zero0, out_valid0, out_last0, done0};
   assign obs1 = {busy1, in_ready1, pad_zero1, iter_en1, residual_clr1,
                  sel_force_zero1, out_valid1, out_last1, done1};

   // Move to 1 time unit after the next rising edge; inputs are driven here
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      // reset and start together: reset must win
      start0 = 1'b1;
      sel_digit0 = 2'b11;
      cyc();
      reset = 1'b0;
      start0 = 1'b0;
      #1;
      checks++;
      if (obs0 !== 9'b000001000) begin
         errs++;
         $display("FAIL reset_flags got %b exp %b", obs0, 9'b000001000);
      end
      checks++;
      if ({iter_idx0, out_digit0} !== {4'd0, 2'b00}) begin
         errs++;
         $display("FAIL reset_idx_digit got %h/%b exp 0/00", iter_idx0, out_digit0);
      end
   endtask

   task automatic test_nominal();
      int iters;
      int beats;
      logic [8:0] exp;
      logic [1:0] d;
      iters = 0;
      beats = 0;
      cyc();
      start0 = 1'b1; in_valid0 = 1'b1; out_ready0 = 1'b1;
      #1;
      checks++;
      if ({busy0, residual_clr0} !== 2'b00) begin
         errs++;
         $display("FAIL nom_start_cycle got busy=%b clr=%b exp 0 0", busy0, residual_clr0);
      end
      for (int k = 1; k <= 11; k++) begin
         cyc();
         start0 = 1'b0;
         d = (k % 2 == 1) ? 2'b01 : 2'b11;
         sel_digit0 = d;
         #1;
         exp = {1'b1, k <= 8, k > 8, 1'b1, k == 1, k <= 3, k >= 4, k == 11, 1'b0};
         checks++;
         if (obs0 !== exp) begin
            errs++;
            $display("FAIL nom_flags c%0d got %b exp %b", k, obs0, exp);
         end
         checks++;
         if (iter_idx0 !== 4'(k - 1)) begin
            errs++;
            $display("FAIL nom_idx c%0d got %0d exp %0d", k, iter_idx0, k - 1);
         end
         checks++;
         if (out_digit0 !== ((k >= 4) ? d : 2'b00)) begin
            errs++;
            $display("FAIL nom_digit c%0d got %b exp %b", k, out_digit0, (k >= 4) ? d : 2'b00);
         end
         iters += int'(iter_en0);
         beats += int'(out_valid0);
      end
      cyc();
      #1;
      checks++;
      if (obs0 !== 9'b000001001) begin
         errs++;
         $display("FAIL nom_done got %b exp %b", obs0, 9'b000001001);
      end
      cyc();
      #1;
      checks++;
      if (done0 !== 1'b0) begin
         errs++;
         $display("FAIL nom_done_pulse got %b exp 0", done0);
      end
      checks++;
      if (iters != 11 || beats != 8) begin
         errs++;
         $display("FAIL nom_counts got iters=%0d beats=%0d exp 11 8", iters, beats);
      end
   endtask

   task automatic test_in_stall();
      int donec;
      donec = -1;
      cyc();
      start0 = 1'b1; in_valid0 = 1'b1; out_ready0 = 1'b1; sel_digit0 = 2'b01;
      #1;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         start0 = 1'b0;
         in_valid0 = !(k == 2 || k == 3);
         #1;
         if (k == 2 || k == 3) begin
            checks++;
            if ({iter_idx0, iter_en0, in_ready0, sel_force_zero0, out_valid0} !==
                {4'd1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
               errs++;
               $display("FAIL in_stall c%0d got idx=%0d it=%b ir=%b sfz=%b ov=%b exp 1 0 1 1 0",
                        k, iter_idx0, iter_en0, in_ready0, sel_force_zero0, out_valid0);
            end
         end
         if (done0 === 1'b1 && donec < 0) donec = k;
      end
      in_valid0 = 1'b1;
      checks++;
      if (donec != 14) begin
         errs++;
         $display("FAIL in_stall_done got cycle %0d exp 14", donec);
      end
   endtask

   task automatic test_out_stall();
      int donec;
      logic stall;
      donec = -1;
      cyc();
      start0 = 1'b1; in_valid0 = 1'b1; out_ready0 = 1'b1; sel_digit0 = 2'b01;
      #1;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         start0 = 1'b0;
         stall = (k >= 6 && k <= 8);
         out_ready0 = !stall;
         sel_digit0 = (k >= 6 && k <= 9) ? 2'b11 : 2'b01;
         #1;
         if (stall) begin
            checks++;
            if ({iter_idx0, out_valid0, out_digit0, in_ready0, iter_en0} !==
                {4'd5, 1'b1, 2'b11, 1'b0, 1'b0}) begin
               errs++;
               $display("FAIL out_stall c%0d got idx=%0d ov=%b dg=%b ir=%b it=%b exp 5 1 11 0 0",
                        k, iter_idx0, out_valid0, out_digit0, in_ready0, iter_en0);
            end
         end
         if (k == 9) begin
            checks++;
            if ({iter_idx0, iter_en0, in_ready0} !== {4'd5, 1'b1, 1'b1}) begin
               errs++;
               $display("FAIL out_release got idx=%0d it=%b ir=%b exp 5 1 1",
                        iter_idx0, iter_en0, in_ready0);
            end
         end
         if (done0 === 1'b1 && donec < 0) donec = k;
      end
      checks++;
      if (donec != 15) begin
         errs++;
         $display("FAIL out_stall_done got cycle %0d exp 15", donec);
      end
   endtask

   task automatic test_reset_mid();
      int dones;
      int iters;
      int donec;
      dones = 0; iters = 0; donec = -1;
      cyc();
      start0 = 1'b1; in_valid0 = 1'b1; out_ready0 = 1'b1;
      #1;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         start0 = 1'b0;
         #1;
      end
      checks++;
      if (iter_idx0 !== 4'd6) begin
         errs++;
         $display("FAIL rst_mid_pre got idx=%0d exp 6", iter_idx0);
      end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      checks++;
      if ({busy0, iter_idx0, done0} !== {1'b0, 4'd0, 1'b0}) begin
         errs++;
         $display("FAIL rst_mid_idle got busy=%b idx=%0d done=%b exp 0 0 0", busy0, iter_idx0, done0);
      end
      for (int k = 0; k < 6; k++) begin
         cyc();
         #1;
         dones += int'(done0);
      end
      checks++;
      if (dones != 0) begin
         errs++;
         $display("FAIL rst_mid_no_done got %0d pulses exp 0", dones);
      end
      cyc();
      start0 = 1'b1;
      #1;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         start0 = 1'b0;
         #1;
         iters += int'(iter_en0);
         if (done0 === 1'b1 && donec < 0) donec = k;
      end
      checks++;
      if (iters != 11 || donec != 12) begin
         errs++;
         $display("FAIL rst_mid_rerun got iters=%0d done=%0d exp 11 12", iters, donec);
      end
   endtask

   task automatic test_start_held();
      int dones;
      dones = 0;
      cyc();
      start0 = 1'b1; in_valid0 = 1'b1; out_ready0 = 1'b1;
      #1;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         #1;
         dones += int'(done0);
         if (k == 5) begin
            checks++;
            if ({busy0, iter_idx0} !== {1'b1, 4'd4}) begin
               errs++;
               $display("FAIL held_mid got busy=%b idx=%0d exp 1 4", busy0, iter_idx0);
            end
         end
         if (k == 12) begin
            checks++;
            if ({busy0, done0} !== 2'b01) begin
               errs++;
               $display("FAIL held_end got busy=%b done=%b exp 0 1", busy0, done0);
            end
         end
      end
      cyc();
      #1;
      checks++;
      if ({busy0, iter_idx0, residual_clr0} !== {1'b1, 4'd0, 1'b1}) begin
         errs++;
         $display("FAIL held_restart got busy=%b idx=%0d clr=%b exp 1 0 1",
                  busy0, iter_idx0, residual_clr0);
      end
      checks++;
      if (dones != 1) begin
         errs++;
         $display("FAIL held_single got %0d done pulses exp 1", dones);
      end
      start0 = 1'b0;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_n_eq_delta();
      int inr;
      int pads;
      logic [8:0] exp;
      inr = 0; pads = 0;
      cyc();
      start1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b1; sel_digit1 = 2'b11;
      #1;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         start1 = 1'b0;
         #1;
         exp = {1'b1, k <= 3, k >= 4, 1'b1, k == 1, k <= 3, k >= 4, k == 6, 1'b0};
         checks++;
         if (obs1 !== exp) begin
            errs++;
            $display("FAIL neqd_flags c%0d got %b exp %b", k, obs1, exp);
         end
         checks++;
         if (iter_idx1 !== 3'(k - 1)) begin
            errs++;
            $display("FAIL neqd_idx c%0d got %0d exp %0d", k, iter_idx1, k - 1);
         end
         inr += int'(in_ready1);
         pads += int'(pad_zero1);
      end
      cyc();
      #1;
      checks++;
      if ({busy1, done1} !== 2'b01) begin
         errs++;
         $display("FAIL neqd_done got busy=%b done=%b exp 0 1", busy1, done1);
      end
      checks++;
      if (inr != 3 || pads != 3) begin
         errs++;
         $display("FAIL neqd_counts got in_ready=%0d pad=%0d exp 3 3", inr, pads);
      end
   endtask

   initial begin
      reset = 1'b1;
      start0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; sel_digit0 = 2'b00;
      start1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; sel_digit1 = 2'b00;
      test_reset();
      test_nominal();
      test_in_stall();
      test_out_stall();
      test_reset_mid();
      test_start_held();
      test_n_eq_delta();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
